// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line conditioning.
// No logic here; state encoding, error codes, frame length and the parity helper.
// Imported by ps2_host_tx; the scan-code receiver can import it too.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_CLK,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_PKT_TO   = 2'd2;
    localparam logic [1:0] ERR_NACK     = 2'd3;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 pin: 2-FF synchronizer, then a run-length glitch filter.
// Latency: 2 sync cycles + FILTER_LEN matching samples before the filtered level flips.
// No backpressure; free-running, reset level is 1 (idle bus).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic pin,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples disagreeing with the current filtered level
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte with odd parity and checks the device ack.
// Latency: INHIBIT_CYCLES + 1 cycles of host request, then paced by the device clock (11 falls).
// Backpressure: start is accepted only while busy=0; requests during a transfer are dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int SW = $clog2(START_TIMEOUT) + 1;
    localparam int PW = $clog2(PACKET_TIMEOUT) + 1;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           err_nxt;
    logic [IW-1:0]        inh_cnt;
    logic [SW-1:0]        start_cnt;
    logic [PW-1:0]        pkt_cnt;
    logic [FRAME_LEN-2:0] frame;
    logic [3:0]           bit_idx;
    logic                 cur_bit;
    logic                 clk_f;
    logic                 data_f;
    logic                 clk_prev;
    logic                 fall;
    logic                 accept;
    logic                 inh_end;
    logic                 start_to;
    logic                 pkt_to;
    logic                 in_pkt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .nreset (nreset),
        .pin    (ps2_clk_in),
        .level  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk    (clk),
        .nreset (nreset),
        .pin    (ps2_data_in),
        .level  (data_f)
    );

    assign fall     = clk_prev & ~clk_f;
    assign accept   = (state == IDLE) && start;
    assign in_pkt   = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign inh_end  = inh_cnt == IW'(INHIBIT_CYCLES - 1);
    assign start_to = start_cnt == SW'(START_TIMEOUT - 1);
    assign pkt_to   = pkt_cnt == PW'(PACKET_TIMEOUT - 1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_NONE;
        case (state)
            IDLE:     if (start) state_nxt = INHIBIT;
            INHIBIT:  if (inh_end) state_nxt = REQ;
            REQ:      state_nxt = WAIT_CLK;
            WAIT_CLK: begin
                if (fall) begin
                    state_nxt = SHIFT;
                end else if (start_to) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_START_TO;
                end
            end
            SHIFT: begin
                if (pkt_to) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_PKT_TO;
                end else if (fall && bit_idx == 4'(FRAME_LEN - 2)) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (pkt_to) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_PKT_TO;
                end else if (fall) begin
                    if (data_f) begin
                        state_nxt = ERR;
                        err_nxt   = ERR_NACK;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (pkt_to) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_PKT_TO;
                end else if (clk_f && data_f) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = state != IDLE;
        rx_inhibit  = state != IDLE;
        done        = state == DONE;
        error       = state == ERR;
        ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
        ps2_data_oe = 1'b0;
        case (state)
            REQ, WAIT_CLK: ps2_data_oe = 1'b1;
            SHIFT:         ps2_data_oe = ~cur_bit;
            default:       ps2_data_oe = 1'b0;
        endcase
    end

    // Counters clear outside their own phase, so entering a phase starts them at zero
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            inh_cnt   <= '0;
            start_cnt <= '0;
            pkt_cnt   <= '0;
            clk_prev  <= 1'b1;
            frame     <= '1;
            bit_idx   <= '0;
            cur_bit   <= 1'b1;
            err_code  <= ERR_NONE;
        end else begin
            clk_prev  <= clk_f;
            inh_cnt   <= (state != INHIBIT)  ? '0 : (&inh_cnt)   ? inh_cnt   : inh_cnt + 1'b1;
            start_cnt <= (state != WAIT_CLK) ? '0 : (&start_cnt) ? start_cnt : start_cnt + 1'b1;
            pkt_cnt   <= !in_pkt             ? '0 : (&pkt_cnt)   ? pkt_cnt   : pkt_cnt + 1'b1;
            if (accept) begin
                frame    <= {1'b1, odd_parity(tx_data), tx_data};
                bit_idx  <= '0;
                cur_bit  <= 1'b1;
                err_code <= ERR_NONE;
            end else begin
                if (fall && (state == WAIT_CLK || state == SHIFT)) begin
                    cur_bit <= frame[bit_idx];
                    bit_idx <= bit_idx + 4'd1;
                end
                if (state_nxt == ERR) begin
                    err_code <= err_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 keyboard model on an open-collector bus.
// Timing parameters are scaled down so the whole run stays short.
module tb_ps2_host_tx;

    localparam int INH   = 50;
    localparam int ST_TO = 300;
    localparam int PK_TO = 1000;
    localparam int FL    = 8;
    localparam int H     = 25;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, error, rx_inhibit, ps2_clk_oe, ps2_data_oe;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST_TO),
        .PACKET_TIMEOUT (PK_TO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done)  n_done <= n_done + 1;
        if (error) n_err  <= n_err + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        start   = 1'b1;
        tx_data = b;
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'h00;
    endtask

    // Keyboard model: samples the start bit, clocks nfalls falls, samples on each rise, optional ack.
    task automatic dev_run(input int nfalls, input bit do_ack, input int glitch_at,
                           output logic [10:0] seen, output bit ok, output int t_fall1,
                           output bit glitch_moved);
        logic oe0;
        seen = '1;
        ok = 1'b0;
        t_fall1 = 0;
        glitch_moved = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy && !ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        seen[0] = ps2_data_in;
        for (int i = 1; i <= 10 && i <= nfalls; i++) begin
            if (i == glitch_at) begin
                tick(5);
                oe0 = ps2_data_oe;
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                for (int j = 0; j < 15; j++) begin
                    tick(1);
                    if (ps2_data_oe !== oe0) glitch_moved = 1'b1;
                end
                tick(H - 23);
            end else begin
                tick(H);
            end
            dev_clk = 1'b0;
            if (i == 1) t_fall1 = cyc;
            tick(H);
            seen[i] = ps2_data_in;
            dev_clk = 1'b1;
        end
        if (nfalls >= 11) begin
            tick(H / 2);
            if (do_ack) dev_data = 1'b0;
            tick(H - H / 2);
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            tick(5);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_end(input int max, output bit got_done, output bit got_err, output int t);
        got_done = 1'b0;
        got_err  = 1'b0;
        t = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done || error) begin
                got_done = done;
                got_err  = error;
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        tick(3);
        checks++;
        if ({busy, done, error, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {busy, done, error, rx_inhibit, ps2_clk_oe, ps2_data_oe});
        end
        checks++;
        if (err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_err_code: got %0d want 0", err_code);
        end
        nreset = 1'b1;
        tick(5);
    endtask

    task automatic test_send_ed;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te, nd0, ne0;
        nd0 = n_done;
        ne0 = n_err;
        fork
            begin
                send(8'hED);
                checks++;
                if (busy !== 1'b1 || rx_inhibit !== 1'b1) begin
                    errors++;
                    $display("FAIL ed_busy_after_accept: busy=%b rx_inhibit=%b want 1 1", busy, rx_inhibit);
                end
                dev_run(11, 1'b1, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ed_wait_clk: host never released clock with start bit");
        end
        checks++;
        if (seen !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            errors++;
            $display("FAIL ed_frame: got %b want %b", seen, {1'b1, 1'b1, 8'hED, 1'b0});
        end
        checks++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL ed_done: done=%b error=%b want 1 0", gd, ge);
        end
        checks++;
        if (err_code !== 2'd0) begin
            errors++;
            $display("FAIL ed_err_code: got %0d want 0", err_code);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ed_after_done: busy=%b done=%b want 0 0", busy, done);
        end
        tick(5);
        checks++;
        if (n_done - nd0 !== 1 || n_err - ne0 !== 0) begin
            errors++;
            $display("FAIL ed_pulse_count: done=%0d error=%0d want 1 0", n_done - nd0, n_err - ne0);
        end
    endtask

    task automatic test_send_f4;
        logic [10:0] seen;
        bit ok, gm, gd, ge, rose;
        int tf, te, hi, both;
        hi = 0;
        both = 0;
        rose = 1'b0;
        fork
            for (int i = 0; i < INH + 200; i++) begin
                @(negedge clk);
                if (ps2_clk_oe) begin
                    rose = 1'b1;
                    if (ps2_data_oe) both++;
                    else hi++;
                end else if (rose) begin
                    break;
                end
            end
            begin
                send(8'hF4);
                dev_run(11, 1'b1, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (hi !== INH) begin
            errors++;
            $display("FAIL f4_inhibit_len: got %0d cycles want %0d", hi, INH);
        end
        checks++;
        if (both !== 1) begin
            errors++;
            $display("FAIL f4_req_len: got %0d cycles want 1", both);
        end
        checks++;
        if (seen !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            errors++;
            $display("FAIL f4_frame: got %b want %b", seen, {1'b1, 1'b0, 8'hF4, 1'b0});
        end
        checks++;
        if (gd !== 1'b1 || ok !== 1'b1) begin
            errors++;
            $display("FAIL f4_done: done=%b started=%b want 1 1", gd, ok);
        end
        tick(5);
    endtask

    task automatic test_start_timeout;
        bit found, gd, ge;
        int t0, te;
        found = 1'b0;
        t0 = 0;
        send(8'hFF);
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                found = 1'b1;
                t0 = cyc;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sto_wait_clk: WAIT_CLK not entered");
        end
        wait_end(ST_TO + 100, gd, ge, te);
        checks++;
        if (ge !== 1'b1 || gd !== 1'b0) begin
            errors++;
            $display("FAIL sto_error: error=%b done=%b want 1 0", ge, gd);
        end
        checks++;
        if (te - t0 !== ST_TO) begin
            errors++;
            $display("FAIL sto_time: got %0d cycles want %0d", te - t0, ST_TO);
        end
        checks++;
        if (err_code !== 2'd1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL sto_code: err_code=%0d clk_oe=%b data_oe=%b want 1 0 0",
                     err_code, ps2_clk_oe, ps2_data_oe);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sto_busy: got %b want 0", busy);
        end
        tick(5);
    endtask

    task automatic test_nack;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te;
        fork
            begin
                send(8'h00);
                dev_run(11, 1'b0, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (seen !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL nack_frame: got %b want %b", seen, {1'b1, 1'b1, 8'h00, 1'b0});
        end
        checks++;
        if (ge !== 1'b1 || gd !== 1'b0) begin
            errors++;
            $display("FAIL nack_error: error=%b done=%b want 1 0", ge, gd);
        end
        checks++;
        if (err_code !== 2'd3) begin
            errors++;
            $display("FAIL nack_code: got %0d want 3", err_code);
        end
        tick(40);
    endtask

    task automatic test_pkt_timeout;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te;
        fork
            begin
                send(8'h12);
                dev_run(5, 1'b0, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (ge !== 1'b1 || gd !== 1'b0) begin
            errors++;
            $display("FAIL pto_error: error=%b done=%b want 1 0", ge, gd);
        end
        checks++;
        if (te - tf !== PK_TO + FL + 3) begin
            errors++;
            $display("FAIL pto_time: got %0d cycles after fall 1 want %0d", te - tf, PK_TO + FL + 3);
        end
        checks++;
        if (err_code !== 2'd2) begin
            errors++;
            $display("FAIL pto_code: got %0d want 2", err_code);
        end
        tick(5);
    endtask

    task automatic test_ignore_start;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te;
        fork
            begin
                send(8'hA5);
                dev_run(11, 1'b1, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
            begin
                tick(INH + 150);
                start   = 1'b1;
                tx_data = 8'h3C;
                tick(1);
                start   = 1'b0;
                tx_data = 8'h00;
            end
        join
        checks++;
        if (seen !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL ign_frame: got %b want %b", seen, {1'b1, 1'b1, 8'hA5, 1'b0});
        end
        checks++;
        if (gd !== 1'b1) begin
            errors++;
            $display("FAIL ign_done: got %b want 1", gd);
        end
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_requeue: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te, nd0, ne0;
        nd0 = n_done;
        ne0 = n_err;
        send(8'h00);
        dev_run(3, 1'b0, 0, seen, ok, tf, gm);
        checks++;
        if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: data_oe=%b busy=%b want 1 1", ps2_data_oe, busy);
        end
        #3 nreset = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async: clk_oe,data_oe,busy,done,error=%b want 00000",
                     {ps2_clk_oe, ps2_data_oe, busy, done, error});
        end
        tick(2);
        nreset = 1'b1;
        tick(20);
        checks++;
        if (n_done - nd0 !== 0 || n_err - ne0 !== 0) begin
            errors++;
            $display("FAIL rst_no_pulse: done=%0d error=%0d want 0 0", n_done - nd0, n_err - ne0);
        end
        fork
            begin
                send(8'h3C);
                dev_run(11, 1'b1, 0, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (seen !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL rst_next_frame: got %b want %b", seen, {1'b1, 1'b1, 8'h3C, 1'b0});
        end
        checks++;
        if (gd !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL rst_next_done: done=%b err_code=%0d want 1 0", gd, err_code);
        end
        tick(5);
    endtask

    task automatic test_glitch;
        logic [10:0] seen;
        bit ok, gm, gd, ge;
        int tf, te;
        fork
            begin
                send(8'h55);
                dev_run(11, 1'b1, 4, seen, ok, tf, gm);
            end
            wait_end(3000, gd, ge, te);
        join
        checks++;
        if (gm !== 1'b0) begin
            errors++;
            $display("FAIL glitch_oe_moved: got %b want 0", gm);
        end
        checks++;
        if (seen !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
            errors++;
            $display("FAIL glitch_frame: got %b want %b", seen, {1'b1, 1'b1, 8'h55, 1'b0});
        end
        checks++;
        if (gd !== 1'b1) begin
            errors++;
            $display("FAIL glitch_done: got %b want 1", gd);
        end
        tick(5);
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_start_timeout();
        test_nack();
        test_pkt_timeout();
        test_ignore_start();
        test_reset_mid();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
